// File: rtl/mpt_walk_arbiter_if.sv
// Bus bundle between the PLB-miss requesters, the walk arbiter and the MPT walker.
// slave = arbiter side, master = environment (requesters + walker) side.
interface mpt_walk_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int REQ_W   = 72
);
   logic                            flush_i;
   logic [NUM_REQ-1:0]              req_valid_i;
   logic [NUM_REQ-1:0]              req_ready_o;
   logic [NUM_REQ-1:0][REQ_W-1:0]   req_i;
   logic [NUM_REQ-1:0]              rsp_valid_o;
   logic                            rsp_allow_o;
   logic [2:0]                      rsp_fault_o;
   logic                            walk_valid_o;
   logic                            walk_ready_i;
   logic [REQ_W-1:0]                walk_req_o;
   logic                            walk_done_i;
   logic                            walk_allow_i;
   logic [2:0]                      walk_fault_i;
   logic                            busy_o;

   modport slave (
      input  flush_i, req_valid_i, req_i, walk_ready_i, walk_done_i, walk_allow_i, walk_fault_i,
      output req_ready_o, rsp_valid_o, rsp_allow_o, rsp_fault_o, walk_valid_o, walk_req_o, busy_o
   );

   modport master (
      output flush_i, req_valid_i, req_i, walk_ready_i, walk_done_i, walk_allow_i, walk_fault_i,
      input  req_ready_o, rsp_valid_o, rsp_allow_o, rsp_fault_o, walk_valid_o, walk_req_o, busy_o
   );
endinterface

// File: rtl/mpt_walk_arbiter.sv
// Round-robin arbiter sharing one MPT walker between NUM_REQ PLB-miss requesters.
// One walk in flight; flush aborts it, draining the walker if it already took the request.
module mpt_walk_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int REQ_W   = 72
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   mpt_walk_arbiter_if.slave   bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [2:0] NO_ERROR = 3'b000;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_RESPOND = 3'd3,
      S_DRAIN   = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [REQ_W-1:0]   req_q, req_d;
   logic               allow_q, allow_d;
   logic [2:0]         fault_q, fault_d;

   logic               found;
   logic [IDX_W-1:0]   win;
   logic [IDX_W-1:0]   idx;

   logic [NUM_REQ-1:0] req_ready;
   logic [NUM_REQ-1:0] rsp_valid;
   logic               rsp_allow;
   logic [2:0]         rsp_fault;
   logic               walk_valid;

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
      if (p == IDX_W'(NUM_REQ - 1)) return '0;
      return p + 1'b1;
   endfunction

   // First pending requester at or after rr_ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!found && bus.req_valid_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      req_d      = req_q;
      allow_d    = allow_q;
      fault_d    = fault_q;
      req_ready  = '0;
      rsp_valid  = '0;
      rsp_allow  = 1'b0;
      rsp_fault  = NO_ERROR;
      walk_valid = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (found && !bus.flush_i) begin
               req_ready[win] = 1'b1;
               req_d          = bus.req_i[win];
               owner_d        = win;
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            walk_valid = 1'b1;
            // Once the walker has taken the request a flush must still wait for its completion.
            if (bus.walk_ready_i) state_d = bus.flush_i ? S_DRAIN : S_WAIT;
            else if (bus.flush_i) state_d = S_IDLE;
         end
         S_WAIT: begin
            if (bus.walk_done_i) begin
               if (bus.flush_i) begin
                  state_d = S_IDLE;
               end else begin
                  allow_d = bus.walk_allow_i;
                  fault_d = bus.walk_fault_i;
                  state_d = S_RESPOND;
               end
            end else if (bus.flush_i) begin
               state_d = S_DRAIN;
            end
         end
         S_RESPOND: begin
            rsp_valid[owner_q] = 1'b1;
            rsp_allow          = allow_q;
            rsp_fault          = fault_q;
            rr_ptr_d           = next_ptr(owner_q);
            state_d            = S_IDLE;
         end
         S_DRAIN: begin
            if (bus.walk_done_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         req_q    <= '0;
         allow_q  <= 1'b0;
         fault_q  <= NO_ERROR;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         req_q    <= req_d;
         allow_q  <= allow_d;
         fault_q  <= fault_d;
      end
   end

   assign bus.req_ready_o  = req_ready;
   assign bus.rsp_valid_o  = rsp_valid;
   assign bus.rsp_allow_o  = rsp_allow;
   assign bus.rsp_fault_o  = rsp_fault;
   assign bus.walk_valid_o = walk_valid;
   assign bus.walk_req_o   = req_q;
   assign bus.busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_mpt_walk_arbiter.sv
// Directed bench for mpt_walk_arbiter; responses are checked against a scoreboard queue.
module tb_mpt_walk_arbiter;
   localparam int NUM_REQ = 2;
   localparam int REQ_W   = 72;

   typedef struct packed {
      logic [NUM_REQ-1:0] vec;
      logic               allow;
      logic [2:0]         fault;
   } rsp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   rsp_cnt = 0;
   rsp_t sb[$];

   mpt_walk_arbiter_if #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) bus ();

   mpt_walk_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: every rsp_valid pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid_o != '0) begin
         rsp_t e;
         rsp_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_rsp observed=%0h expected=none", bus.rsp_valid_o);
         end else begin
            e = sb.pop_front();
            chk("rsp_valid", bus.rsp_valid_o, e.vec);
            chk("rsp_allow", bus.rsp_allow_o, e.allow);
            chk("rsp_fault", bus.rsp_fault_o, e.fault);
         end
      end
   end

   // One full walk starting in IDLE at posedge+1 with the requester(s) already presenting.
   task automatic walk_one(input int owner, input logic allow, input logic [2:0] fault, input int stall);
      logic [NUM_REQ-1:0] onehot;
      logic [REQ_W-1:0]   exp_req;
      int                 n0;
      onehot  = '0;
      onehot[owner] = 1'b1;
      exp_req = bus.req_i[owner];
      n0      = rsp_cnt;
      @(negedge clk);
      chk("grant", bus.req_ready_o, onehot);
      chk("idle_busy", bus.busy_o, 1'b0);
      tick();
      bus.walk_ready_i = 1'b0;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_walk_valid", bus.walk_valid_o, 1'b1);
         chk("stall_walk_req", bus.walk_req_o, exp_req);
         chk("stall_no_accept", bus.req_ready_o, '0);
         tick();
      end
      bus.walk_ready_i = 1'b1;
      @(negedge clk);
      chk("issue_walk_valid", bus.walk_valid_o, 1'b1);
      chk("issue_walk_req", bus.walk_req_o, exp_req);
      tick();
      bus.walk_ready_i  = 1'b0;
      bus.walk_done_i   = 1'b1;
      bus.walk_allow_i  = allow;
      bus.walk_fault_i  = fault;
      sb.push_back('{vec: onehot, allow: allow, fault: fault});
      @(negedge clk);
      chk("wait_walk_valid", bus.walk_valid_o, 1'b0);
      tick();
      bus.walk_done_i  = 1'b0;
      bus.walk_allow_i = 1'b0;
      bus.walk_fault_i = 3'b000;
      @(negedge clk);
      chk("respond_no_accept", bus.req_ready_o, '0);
      tick();
      chk("rsp_count", rsp_cnt, n0 + 1);
      chk("rsp_idle_allow", bus.rsp_allow_o, 1'b0);
      chk("rsp_idle_fault", bus.rsp_fault_o, 3'b000);
   endtask

   initial begin
      int n0;
      rst_n            = 1'b0;
      bus.flush_i      = 1'b0;
      bus.req_valid_i  = '0;
      bus.req_i[0]     = 72'hA1_0123_4567_89AB_CDEF;
      bus.req_i[1]     = 72'h5C_FEDC_BA98_7654_3210;
      bus.walk_ready_i = 1'b0;
      bus.walk_done_i  = 1'b0;
      bus.walk_allow_i = 1'b0;
      bus.walk_fault_i = 3'b000;

      @(negedge clk);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_walk_valid", bus.walk_valid_o, 1'b0);
      chk("rst_walk_req", bus.walk_req_o, '0);
      chk("rst_rsp_valid", bus.rsp_valid_o, '0);
      chk("rst_rsp_fault", bus.rsp_fault_o, 3'b000);
      tick();
      rst_n = 1'b1;

      // Single requester, minimum latency, allowed.
      bus.req_valid_i = 2'b01;
      walk_one(0, 1'b1, 3'b000, 0);

      // Both requesting continuously: grants alternate (pointer now at 1).
      bus.req_valid_i = 2'b11;
      walk_one(1, 1'b1, 3'b000, 0);
      walk_one(0, 1'b0, 3'b001, 0);
      walk_one(1, 1'b1, 3'b000, 0);
      walk_one(0, 1'b1, 3'b000, 0);

      // Fault NOT_VALID_ENTRY for requester 1.
      bus.req_valid_i = 2'b10;
      walk_one(1, 1'b0, 3'b010, 0);

      // Walker stalls 5 cycles while the other requester waits.
      bus.req_valid_i = 2'b11;
      walk_one(0, 1'b1, 3'b000, 5);

      // Flush in WAIT -> DRAIN, completion 3 cycles later is discarded.
      n0 = rsp_cnt;
      @(negedge clk);
      chk("drain_grant", bus.req_ready_o, 2'b10);
      tick();
      bus.walk_ready_i = 1'b1;
      tick();
      bus.walk_ready_i = 1'b0;
      bus.flush_i      = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      @(negedge clk);
      chk("drain_busy", bus.busy_o, 1'b1);
      chk("drain_no_accept", bus.req_ready_o, '0);
      chk("drain_walk_valid", bus.walk_valid_o, 1'b0);
      tick();
      tick();
      bus.walk_done_i  = 1'b1;
      bus.walk_allow_i = 1'b1;
      tick();
      bus.walk_done_i  = 1'b0;
      bus.walk_allow_i = 1'b0;
      chk("drain_exit_busy", bus.busy_o, 1'b0);
      @(negedge clk);
      chk("drain_ptr_kept", bus.req_ready_o, 2'b10);

      // Flush in ISSUE without ready -> straight back to IDLE.
      tick();
      bus.flush_i = 1'b1;
      @(negedge clk);
      chk("issue_flush_valid", bus.walk_valid_o, 1'b1);
      tick();
      bus.flush_i = 1'b0;
      chk("issue_flush_idle", bus.busy_o, 1'b0);
      @(negedge clk);
      chk("issue_flush_ptr", bus.req_ready_o, 2'b10);

      // Flush together with ready -> DRAIN until the walker completes.
      tick();
      bus.flush_i      = 1'b1;
      bus.walk_ready_i = 1'b1;
      tick();
      bus.flush_i      = 1'b0;
      bus.walk_ready_i = 1'b0;
      @(negedge clk);
      chk("ready_flush_drain", bus.busy_o, 1'b1);
      tick();
      bus.walk_done_i = 1'b1;
      tick();
      bus.walk_done_i = 1'b0;
      chk("ready_flush_idle", bus.busy_o, 1'b0);
      chk("flush_no_rsp", rsp_cnt, n0);
      @(negedge clk);
      chk("ready_flush_ptr", bus.req_ready_o, 2'b10);

      // Asynchronous reset in the middle of WAIT.
      tick();
      bus.walk_ready_i = 1'b1;
      tick();
      bus.walk_ready_i = 1'b0;
      #2;
      bus.req_valid_i = '0;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy_o, 1'b0);
      chk("arst_walk_valid", bus.walk_valid_o, 1'b0);
      chk("arst_walk_req", bus.walk_req_o, '0);
      chk("arst_req_ready", bus.req_ready_o, '0);
      chk("arst_rsp_valid", bus.rsp_valid_o, '0);
      chk("arst_rsp_fault", bus.rsp_fault_o, 3'b000);
      tick();
      rst_n = 1'b1;
      bus.req_valid_i = 2'b11;
      @(negedge clk);
      chk("arst_ptr_zero", bus.req_ready_o, 2'b01);
      tick();
      bus.req_valid_i = '0;
      @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
